// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the controller FSM and the target.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_LOAD,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } i2c_tgt_state_t;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;
    localparam logic I2C_ACK      = 1'b0;
    localparam logic I2C_NACK     = 1'b1;

    localparam logic [3:0] I2C_BYTE_BITS = 4'd8;

    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] addr);
        return addr_byte[7:1] == addr;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers with registered edge and START/STOP detection.
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_prev;
    logic       sda_prev;

    // Lines reset to the idle-high level so no edge is seen coming out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync  <= 2'b11;
            sda_sync  <= 2'b11;
            scl_prev  <= 1'b1;
            sda_prev  <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            sda_s     <= 1'b1;
        end else begin
            scl_sync  <= {scl_sync[0], scl_i};
            sda_sync  <= {sda_sync[0], sda_i};
            scl_prev  <= scl_sync[1];
            sda_prev  <= sda_sync[1];
            scl_rise  <= scl_sync[1] & ~scl_prev;
            scl_fall  <= ~scl_sync[1] & scl_prev;
            start_det <= scl_sync[1] & scl_prev & sda_prev & ~sda_sync[1];
            stop_det  <= scl_sync[1] & scl_prev & ~sda_prev & sda_sync[1];
            sda_s     <= sda_sync[1];
        end
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target: 7-bit address match, byte write/read through a strobe handshake.
// Define I2C_TGT_STRETCH_EN to stretch SCL while waiting for read data.
module i2c_target #(
    parameter logic [6:0] ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       nack_tick,
    output logic       busy
);

    import i2c_pkg::*;

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_s;

    i2c_line_sync u_line_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    i2c_tgt_state_t state;
    logic [3:0]     bit_cnt;
    logic [7:0]     shift_reg;
    logic [7:0]     tx_shift;
    logic           rw;
    logic           ack_seen;

`ifdef I2C_TGT_STRETCH_EN
    logic scl_hold;
    assign scl_oe = scl_hold;
`else
    assign scl_oe = 1'b0;
`endif

    // STOP and START override every state; otherwise bits move on the synchronized SCL edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= 4'd0;
            shift_reg <= 8'h00;
            tx_shift  <= 8'hFF;
            rw        <= I2C_RW_WRITE;
            ack_seen  <= 1'b0;
            sda_oe    <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            nack_tick <= 1'b0;
            busy      <= 1'b0;
`ifdef I2C_TGT_STRETCH_EN
            scl_hold  <= 1'b0;
`endif
        end else begin
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            nack_tick <= 1'b0;
`ifdef I2C_TGT_STRETCH_EN
            scl_hold  <= 1'b0;
`endif
            if (stop_det) begin
                state   <= ST_IDLE;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else if (start_det) begin
                state   <= ST_ADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_IGNORE: begin
                        sda_oe <= 1'b0;
                    end

                    ST_ADDR: begin
                        if (scl_rise && bit_cnt != I2C_BYTE_BITS) begin
                            shift_reg <= {shift_reg[6:0], sda_s};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == I2C_BYTE_BITS) begin
                            bit_cnt <= 4'd0;
                            if (addr_match(shift_reg, ADDR)) begin
                                state  <= ST_ADDR_ACK;
                                rw     <= shift_reg[0];
                                sda_oe <= ~I2C_ACK;
                                busy   <= 1'b1;
                            end else begin
                                state  <= ST_IGNORE;
                                sda_oe <= 1'b0;
                                busy   <= 1'b0;
                            end
                        end
                    end

                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 4'd0;
                            state   <= (rw == I2C_RW_WRITE) ? ST_WR_DATA : ST_RD_LOAD;
                            tx_req  <= (rw == I2C_RW_READ);
                        end
                    end

                    ST_WR_DATA: begin
                        if (scl_rise && bit_cnt != I2C_BYTE_BITS) begin
                            shift_reg <= {shift_reg[6:0], sda_s};
                            bit_cnt   <= bit_cnt + 4'd1;
                            if (bit_cnt == I2C_BYTE_BITS - 4'd1) begin
                                rx_data  <= {shift_reg[6:0], sda_s};
                                rx_valid <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt == I2C_BYTE_BITS) begin
                            sda_oe <= ~I2C_ACK;
                            state  <= ST_WR_ACK;
                        end
                    end

                    ST_WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 4'd0;
                            state   <= ST_WR_DATA;
                        end
                    end

                    // The MSB goes out as soon as the byte arrives; later bits follow scl_fall.
                    ST_RD_LOAD: begin
`ifdef I2C_TGT_STRETCH_EN
                        if (tx_valid) begin
                            tx_shift <= tx_data;
                            sda_oe   <= ~tx_data[7];
                            bit_cnt  <= 4'd0;
                            state    <= ST_RD_DATA;
                            scl_hold <= scl_hold;
                        end else begin
                            scl_hold <= 1'b1;
                        end
`else
                        if (scl_rise) begin
                            tx_shift <= 8'hFF;
                            sda_oe   <= 1'b0;
                            bit_cnt  <= 4'd1;
                            state    <= ST_RD_DATA;
                        end else if (tx_valid) begin
                            tx_shift <= tx_data;
                            sda_oe   <= ~tx_data[7];
                            bit_cnt  <= 4'd0;
                            state    <= ST_RD_DATA;
                        end
`endif
                    end

                    ST_RD_DATA: begin
                        if (scl_rise && bit_cnt != I2C_BYTE_BITS) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == I2C_BYTE_BITS) begin
                                sda_oe   <= 1'b0;
                                ack_seen <= 1'b0;
                                state    <= ST_RD_ACK;
                            end else begin
                                sda_oe   <= ~tx_shift[6];
                                tx_shift <= {tx_shift[6:0], 1'b1};
                            end
                        end
                    end

                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_s == I2C_NACK) begin
                                nack_tick <= 1'b1;
                                state     <= ST_IGNORE;
                            end else begin
                                ack_seen <= 1'b1;
                            end
                        end else if (scl_fall && ack_seen) begin
                            bit_cnt <= 4'd0;
                            tx_req  <= 1'b1;
                            state   <= ST_RD_LOAD;
                        end
                    end

                    default: begin
                        state  <= ST_IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
